race_control: RTL and testbench

Race sequencer for the two-player racer. Takes each car's `lap_finished` / `checkpoints_passed` flags from its checkpoint detector, runs the start countdown, credits only valid laps, detects the winner and keeps race time. Outputs feed the car movement logic (`race_active` gate) and the HUD/text overlay (laps, countdown, winner, time).

---
 rtl/race_pkg.sv | 27 ++
 rtl/lap_qualifier.sv | 57 +++++
 rtl/race_control.sv | 153 +++++++++++++++
 tb/tb_race_control.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared encodings and helpers for the two-player race sequencer.
package race_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned LAP_W   = 4;
  localparam int unsigned TIME_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACING    = 2'd2,
    FINISHED  = 2'd3
  } race_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    TIE  = 2'd3
  } winner_t;

  // Pixel-clock cycles per centisecond.
  function automatic int unsigned cs_div(input int unsigned clk_hz);
    return clk_hz / 100;
  endfunction

endpackage

// File: rtl/lap_qualifier.sv
// Per-player lap crediting: finish-zone entry edge qualified by the checkpoint
// flag from before the detector cleared it, into a saturating lap counter.
module lap_qualifier
  import race_pkg::*;
#(
  parameter int unsigned LAPS = 3
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             lap_finished,
  input  logic             checkpoints_passed,
  input  logic             clear,
  input  logic             enable,
  output logic [LAP_W-1:0] laps,
  output logic             lap_won_c
);

  logic             r_lap_finished;
  logic             r_lap_finished_d;
  logic             r_checkpoints;
  logic             r_checkpoints_d;
  logic [LAP_W-1:0] r_laps;
  logic             w_credit;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_finished   <= 1'b0;
      r_lap_finished_d <= 1'b0;
      r_checkpoints    <= 1'b0;
      r_checkpoints_d  <= 1'b0;
    end else begin
      r_lap_finished   <= lap_finished;
      r_lap_finished_d <= r_lap_finished;
      r_checkpoints    <= checkpoints_passed;
      r_checkpoints_d  <= r_checkpoints;
    end
  end

  // One credit per zone entry; the delayed checkpoint flag survives the detector's clear.
  assign w_credit = enable && r_lap_finished && !r_lap_finished_d && r_checkpoints_d
                    && (r_laps < LAP_W'(LAPS));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_laps <= '0;
    end else if (clear) begin
      r_laps <= '0;
    end else if (w_credit) begin
      r_laps <= r_laps + LAP_W'(1);
    end
  end

  // Fires in the cycle the credit lands, so the sequencer finishes on the same edge.
  assign lap_won_c = w_credit && (r_laps == LAP_W'(LAPS - 1));
  assign laps      = r_laps;

endmodule

// File: rtl/race_control.sv
// Race sequencer: start countdown, lap crediting, winner detection and race time.
// Build option RACE_TIMER_EN enables the centisecond race_time counter (else tied to 0).
module race_control
  import race_pkg::*;
#(
  parameter int unsigned LAPS        = 3,
  parameter int unsigned CLK_HZ      = 65_000_000,
  parameter int unsigned COUNTDOWN_S = 3
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              p1_lap_finished,
  input  logic              p2_lap_finished,
  input  logic              p1_checkpoints_passed,
  input  logic              p2_checkpoints_passed,
  output logic [STATE_W-1:0] state,
  output logic [1:0]        countdown,
  output logic              race_active,
  output logic [LAP_W-1:0]  p1_laps,
  output logic [LAP_W-1:0]  p2_laps,
  output logic [1:0]        winner,
  output logic [TIME_W-1:0] race_time
);

  localparam int unsigned SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  race_state_t      r_state;
  logic [1:0]       r_countdown;
  logic             r_race_active;
  winner_t          r_winner;
  logic [SEC_W-1:0] r_sec_cnt;

  logic w_racing;
  logic w_lap_clear;
  logic w_p1_won;
  logic w_p2_won;

  assign w_racing    = (r_state == RACING);
  assign w_lap_clear = start && ((r_state == IDLE) || (r_state == FINISHED));

  lap_qualifier #(.LAPS(LAPS)) u_p1_lap (
    .pclk               (pclk),
    .rst_n              (rst_n),
    .lap_finished       (p1_lap_finished),
    .checkpoints_passed (p1_checkpoints_passed),
    .clear              (w_lap_clear),
    .enable             (w_racing),
    .laps               (p1_laps),
    .lap_won_c          (w_p1_won)
  );

  lap_qualifier #(.LAPS(LAPS)) u_p2_lap (
    .pclk               (pclk),
    .rst_n              (rst_n),
    .lap_finished       (p2_lap_finished),
    .checkpoints_passed (p2_checkpoints_passed),
    .clear              (w_lap_clear),
    .enable             (w_racing),
    .laps               (p2_laps),
    .lap_won_c          (w_p2_won)
  );

  // Race sequencer FSM with registered countdown, gate and winner.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_countdown   <= 2'd0;
      r_race_active <= 1'b0;
      r_winner      <= NONE;
      r_sec_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= COUNTDOWN;
            r_countdown <= 2'(COUNTDOWN_S);
            r_winner    <= NONE;
            r_sec_cnt   <= '0;
          end
        end
        COUNTDOWN: begin
          if (r_sec_cnt == SEC_W'(CLK_HZ - 1)) begin
            r_sec_cnt <= '0;
            if (r_countdown == 2'd1) begin
              r_state       <= RACING;
              r_countdown   <= 2'd0;
              r_race_active <= 1'b1;
            end else begin
              r_countdown <= r_countdown - 2'd1;
            end
          end else begin
            r_sec_cnt <= r_sec_cnt + SEC_W'(1);
          end
        end
        RACING: begin
          if (w_p1_won || w_p2_won) begin
            r_state       <= FINISHED;
            r_race_active <= 1'b0;
            r_winner      <= winner_t'({w_p2_won, w_p1_won});
          end
        end
        FINISHED: begin
          if (start) begin
            r_state  <= IDLE;
            r_winner <= NONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RACE_TIMER_EN
  localparam int unsigned CS_DIV = cs_div(CLK_HZ);
  localparam int unsigned CS_W   = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;

  logic [CS_W-1:0]   r_cs_cnt;
  logic [TIME_W-1:0] r_race_time;

  // Centisecond timer: runs only while racing, saturates instead of wrapping.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_cnt    <= '0;
      r_race_time <= '0;
    end else if (w_lap_clear) begin
      r_cs_cnt    <= '0;
      r_race_time <= '0;
    end else if (w_racing) begin
      if (r_cs_cnt == CS_W'(CS_DIV - 1)) begin
        r_cs_cnt <= '0;
        if (r_race_time != '1) begin
          r_race_time <= r_race_time + TIME_W'(1);
        end
      end else begin
        r_cs_cnt <= r_cs_cnt + CS_W'(1);
      end
    end else begin
      r_cs_cnt <= '0;
    end
  end

  assign race_time = r_race_time;
`else
  assign race_time = '0;
`endif

  assign state       = r_state;
  assign countdown   = r_countdown;
  assign race_active = r_race_active;
  assign winner      = r_winner;

endmodule

// File: tb/tb_race_control.sv
// Scoreboard bench for race_control: stimulus queues expected output events,
// a negedge monitor pops and compares on every output change or sample request.
module tb_race_control;

  localparam int unsigned TB_CLK_HZ = 100;
  localparam int unsigned TB_CS_DIV = TB_CLK_HZ / 100;
  localparam int unsigned SEC       = TB_CLK_HZ;
`ifdef RACE_TIMER_EN
  localparam bit TB_TIMER = 1'b1;
`else
  localparam bit TB_TIMER = 1'b0;
`endif

  logic        pclk  = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        p1_lf = 1'b0, p2_lf = 1'b0, p1_cp = 1'b0, p2_cp = 1'b0;
  logic [1:0]  state, countdown, winner;
  logic        race_active;
  logic [3:0]  p1_laps, p2_laps;
  logic [15:0] race_time;

  race_control #(.LAPS(3), .CLK_HZ(TB_CLK_HZ), .COUNTDOWN_S(3)) dut (
    .pclk                  (pclk),
    .rst_n                 (rst_n),
    .start                 (start),
    .p1_lap_finished       (p1_lf),
    .p2_lap_finished       (p2_lf),
    .p1_checkpoints_passed (p1_cp),
    .p2_checkpoints_passed (p2_cp),
    .state                 (state),
    .countdown             (countdown),
    .race_active           (race_active),
    .p1_laps               (p1_laps),
    .p2_laps               (p2_laps),
    .winner                (winner),
    .race_time             (race_time)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc++;

  typedef struct {
    string       name;
    int          due;
    logic [1:0]  st;
    logic [1:0]  cd;
    logic        ra;
    logic [3:0]  l1;
    logic [3:0]  l2;
    logic [1:0]  win;
    bit          chk_rt;
    logic [15:0] rt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          sample_req = 1'b0;
  logic [14:0] prev_snap = '0;
  logic [14:0] snap;
  int          r_start = 0;
  logic [15:0] last_rt = '0;

  // Monitor: an output change (race_time excluded) or a sample request consumes one entry.
  always @(negedge pclk) begin
    snap = {state, countdown, race_active, p1_laps, p2_laps, winner};
    if (mon_en && ((snap != prev_snap) || sample_req)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: cyc=%0d st=%0d cd=%0d ra=%0d p1=%0d p2=%0d win=%0d rt=%0d",
                 cyc, state, countdown, race_active, p1_laps, p2_laps, winner, race_time);
      end else begin
        mon_e = exp_q.pop_front();
        if (((mon_e.due >= 0) && (cyc != mon_e.due)) || (state !== mon_e.st) ||
            (countdown !== mon_e.cd) || (race_active !== mon_e.ra) ||
            (p1_laps !== mon_e.l1) || (p2_laps !== mon_e.l2) || (winner !== mon_e.win) ||
            (mon_e.chk_rt && (race_time !== mon_e.rt))) begin
          errors++;
          $display("FAIL %s: got cyc=%0d st=%0d cd=%0d ra=%0d p1=%0d p2=%0d win=%0d rt=%0d, want cyc=%0d st=%0d cd=%0d ra=%0d p1=%0d p2=%0d win=%0d rt=%0d(chk=%0d)",
                   mon_e.name, cyc, state, countdown, race_active, p1_laps, p2_laps, winner, race_time,
                   mon_e.due, mon_e.st, mon_e.cd, mon_e.ra, mon_e.l1, mon_e.l2, mon_e.win, mon_e.rt, mon_e.chk_rt);
        end
      end
    end
    prev_snap = snap;
  end

  function automatic logic [15:0] rt_exp(input int n);
    if (TB_TIMER) return 16'(n / TB_CS_DIV);
    return 16'd0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic push(input string nm, input int due, input logic [1:0] st, input logic [1:0] cd,
                      input logic ra, input logic [3:0] l1, input logic [3:0] l2,
                      input logic [1:0] win, input bit chk_rt, input logic [15:0] rt);
    exp_t e;
    e.name = nm; e.due = due; e.st = st; e.cd = cd; e.ra = ra;
    e.l1 = l1; e.l2 = l2; e.win = win; e.chk_rt = chk_rt; e.rt = rt;
    exp_q.push_back(e);
  endtask

  task automatic sample(input string nm, input logic [1:0] st, input logic [1:0] cd, input logic ra,
                        input logic [3:0] l1, input logic [3:0] l2, input logic [1:0] win,
                        input bit chk_rt, input logic [15:0] rt);
    push(nm, -1, st, cd, ra, l1, l2, win, chk_rt, rt);
    sample_req = 1'b1;
    @(negedge pclk);
    #1 sample_req = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  // Start pulse from IDLE; countdown 3/2/1 one second apart, racing after three seconds.
  task automatic run_countdown();
    int c;
    c = cyc;
    push("cd3", c + 1,           2'd1, 2'd3, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd0);
    push("cd2", c + 1 + SEC,     2'd1, 2'd2, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd0);
    push("cd1", c + 1 + 2 * SEC, 2'd1, 2'd1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd0);
    push("go",  c + 1 + 3 * SEC, 2'd2, 2'd0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b1, 16'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3 * SEC);
    r_start = cyc;
  endtask

  // Valid lap(s): checkpoints set early, cleared on zone entry as the detector does.
  task automatic do_lap(input bit a, input bit b, input string nm, input logic [3:0] l1,
                        input logic [3:0] l2, input logic [1:0] st, input logic [1:0] win, input bit chk_rt);
    int c;
    if (a) p1_cp = 1'b1;
    if (b) p2_cp = 1'b1;
    tick(3);
    c = cyc;
    last_rt = rt_exp(c + 2 - r_start);
    push(nm, c + 2, st, 2'd0, (st == 2'd2), l1, l2, win, chk_rt, last_rt);
    if (a) begin p1_lf = 1'b1; p1_cp = 1'b0; end
    if (b) begin p2_lf = 1'b1; p2_cp = 1'b0; end
    tick(4);
    p1_lf = 1'b0;
    p2_lf = 1'b0;
    tick(2);
  endtask

  task automatic restart_from_finished();
    int c;
    c = cyc;
    push("restart_idle", c + 1, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
  endtask

  initial begin
    int c;
    #2 rst_n = 1'b0;
    tick(3);
    mon_en = 1'b1;
    sample("reset_state", 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd0);
    rst_n = 1'b1;
    tick(2);

    run_countdown();
    tick(250);
    sample("race_time_250", 2'd2, 2'd0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b1, rt_exp(250));

    // Zone entry without checkpoints credits nothing.
    p1_lf = 1'b1;
    tick(5);
    p1_lf = 1'b0;
    tick(3);
    sample("invalid_lap", 2'd2, 2'd0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0, 16'd0);

    // Level held 50 cycles with checkpoints kept high: exactly one credit; start ignored.
    p1_cp = 1'b1;
    tick(3);
    c = cyc;
    push("p1_lap_held", c + 2, 2'd2, 2'd0, 1'b1, 4'd1, 4'd0, 2'd0, 1'b0, 16'd0);
    p1_lf = 1'b1;
    tick(10);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(39);
    p1_lf = 1'b0;
    p1_cp = 1'b0;
    tick(3);
    sample("held_one_lap", 2'd2, 2'd0, 1'b1, 4'd1, 4'd0, 2'd0, 1'b0, 16'd0);

    do_lap(1'b0, 1'b1, "p2_lap1", 4'd1, 4'd1, 2'd2, 2'd0, 1'b0);
    do_lap(1'b0, 1'b1, "p2_lap2", 4'd1, 4'd2, 2'd2, 2'd0, 1'b0);
    do_lap(1'b0, 1'b1, "p2_win",  4'd1, 4'd3, 2'd3, 2'd2, 1'b1);

    // Laps after the finish are ignored and the clock stays frozen.
    p1_cp = 1'b1;
    tick(3);
    p1_lf = 1'b1;
    p1_cp = 1'b0;
    tick(5);
    p1_lf = 1'b0;
    tick(20);
    sample("frozen", 2'd3, 2'd0, 1'b0, 4'd1, 4'd3, 2'd2, 1'b1, last_rt);

    restart_from_finished();

    run_countdown();
    do_lap(1'b1, 1'b0, "tie_p1a", 4'd1, 4'd0, 2'd2, 2'd0, 1'b0);
    do_lap(1'b0, 1'b1, "tie_p2a", 4'd1, 4'd1, 2'd2, 2'd0, 1'b0);
    do_lap(1'b1, 1'b0, "tie_p1b", 4'd2, 4'd1, 2'd2, 2'd0, 1'b0);
    do_lap(1'b0, 1'b1, "tie_p2b", 4'd2, 4'd2, 2'd2, 2'd0, 1'b0);
    do_lap(1'b1, 1'b1, "tie",     4'd3, 4'd3, 2'd3, 2'd3, 1'b1);

    restart_from_finished();

    // Reset mid-countdown must clear outputs before any further clock edge.
    c = cyc;
    push("cd3_b", c + 1,       2'd1, 2'd3, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd0);
    push("cd2_b", c + 1 + SEC, 2'd1, 2'd2, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(SEC + 50);
    push("async_reset", cyc, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd0);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    sample("after_reset", 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd0);

    // Bounded drain; anything left was never observed.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(1);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no output event, want one due at cyc=%0d", mon_e.name, mon_e.due);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
